sample_loader: RTL and testbench
================================

Name: sample_loader

Overview:
- Upstream feeder for the network controller. Pulls training/inference samples from an external word stream.
- Writes each sample's input vector into layer 0 of the y RAM and its target vector into the target buffer.
- Drives the controller's `done` (hold-in-INIT) and `train` inputs, and sequences samples and epochs.
- Releases the controller for exactly one sample per load; the controller's one-cycle `valid` pulse requests the next sample.

Parameters:
- DATA_WIDTH, 32, width of one fixed-point stream word / RAM word
- N_IN, 4, input words per sample (≤ MAX_NEURONS)
- N_OUT, 4, target words per sample
- NUM_SAMPLES, 16, samples per epoch
- TRAIN_EPOCHS, 8, training epochs before the single final inference epoch
- IDX_W, 8, width of index/counter outputs

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- valid  in  1  controller "sample consumed" pulse (Load_New_IO)
- s_valid  in  1  stream word available
- s_data  in  DATA_WIDTH  stream word
- s_ready  out  1  loader accepts word this cycle
- y0_we  out  1  write strobe, y RAM layer 0
- y0_addr  out  IDX_W  neuron index in layer 0
- y0_data  out  DATA_WIDTH  input value
- t_we  out  1  write strobe, target buffer
- t_addr  out  IDX_W  target index
- t_data  out  DATA_WIDTH  target value
- done  out  1  1 = controller holds in INIT
- train  out  1  1 = controller runs backprop after forward pass
- sample_idx  out  IDX_W  current sample number
- epoch_idx  out  IDX_W  current epoch number
- finished  out  1  all epochs complete
- protocol_err  out  1  sticky: `valid` seen outside RUN

Behaviour:
- Reset values (RST high at an edge):
  - state=LOAD, done=1, train=(TRAIN_EPOCHS>0), s_ready=0.
  - y0_we=t_we=0, all addr/data=0, word_cnt=sample_idx=epoch_idx=0.
  - finished=0, protocol_err=0.
  - Reset mid-LOAD or mid-RUN abandons the sample; no partial write completes after reset.
- States:
  - LOAD:
    - s_ready=1. Each transfer (s_valid&&s_ready) increments word_cnt.
    - word_cnt<N_IN: next cycle y0_we=1, y0_addr=word_cnt, y0_data=s_data.
    - Otherwise: next cycle t_we=1, t_addr=word_cnt-N_IN, t_data=s_data.
    - Write latency is exactly 1 cycle after the transfer; strobes are single-cycle pulses.
    - When the transfer with word_cnt=N_IN+N_OUT-1 occurs: s_ready=0 next cycle, word_cnt<=0, go to ARM.
    - s_valid low stalls with no writes.
  - ARM: one cycle; lets the last write land. done<=0, go to RUN.
  - RUN:
    - done=0, s_ready=0. Wait for `valid`.
    - On `valid`: done<=1 at the same edge, go to NEXT. This guarantees the controller samples done=1 on its first INIT cycle.
  - NEXT: one cycle, updates counters.
    - If sample_idx<NUM_SAMPLES-1: sample_idx++, go to LOAD.
    - Else: sample_idx<=0 and epoch_idx++ (wrap case).
    - If the new epoch_idx==TRAIN_EPOCHS: train<=0.
    - If the new epoch_idx==TRAIN_EPOCHS+1: go to FINISHED; otherwise go to LOAD.
  - FINISHED: done=1, finished=1, s_ready=0, permanent until RST.
- `valid` in LOAD/ARM/NEXT/FINISHED is ignored, with no state change, and sets protocol_err.
- `valid` and the final LOAD transfer in the same cycle: the transfer is taken, `valid` is flagged as an error.
- done is registered: high in every state except RUN, and high in the cycle RUN is entered only if ARM→RUN is not yet complete. Precisely: done=0 exactly from the ARM edge until the `valid` edge.
- Counters are unsigned IDX_W. Parameters must satisfy N_IN+N_OUT ≤ 2^IDX_W and NUM_SAMPLES ≤ 2^IDX_W.
- train changes only in NEXT, never while done=0.

Test Plan:
- Reset behaviour: N_IN=2, N_OUT=1. After RST, stream 0x10,0x20,0x30 back-to-back.
  - y0 writes (0,0x10),(1,0x20) and t write (0,0x30), each 1 cycle after its transfer.
  - done falls 2 cycles after the last transfer; s_ready=0 after the 3rd word.
- Stream stalls: same as above with s_valid toggled 1,0,0,1,0,1.
  - Exactly 3 writes, correct addresses, no writes on stall cycles.
- Epoch wrap / train drop: NUM_SAMPLES=2, TRAIN_EPOCHS=1. Feed 4 samples, pulsing `valid` 10 cycles after each done fall.
  - train=1 for samples 0–1, train=0 for samples 2–3.
  - epoch_idx 0→1→2; finished=1 and done=1 permanently after the 4th `valid`.
- Spurious valid: pulse `valid` during LOAD.
  - protocol_err=1 and sticky; loading continues unaffected.
- Reset mid-operation: assert RST after 1 of 3 words.
  - No further writes; sample_idx=0, done=1.
  - A fresh 3-word stream loads correctly at addresses 0,1,0.
- done/valid timing: check done rises at the edge where `valid`=1 is sampled, and is seen high by the controller's first INIT cycle.

Source files
------------

// File: rtl/sample_loader.sv
// sample_loader: streams per-sample input/target words into layer-0 y RAM
// and target buffer, then releases the network controller for one pass.
module sample_loader #(
  parameter int DATA_WIDTH   = 32,
  parameter int N_IN         = 4,
  parameter int N_OUT        = 4,
  parameter int NUM_SAMPLES  = 16,
  parameter int TRAIN_EPOCHS = 8,
  parameter int IDX_W        = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  valid,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  y0_we,
  output logic [IDX_W-1:0]      y0_addr,
  output logic [DATA_WIDTH-1:0] y0_data,
  output logic                  t_we,
  output logic [IDX_W-1:0]      t_addr,
  output logic [DATA_WIDTH-1:0] t_data,
  output logic                  done,
  output logic                  train,
  output logic [IDX_W-1:0]      sample_idx,
  output logic [IDX_W-1:0]      epoch_idx,
  output logic                  finished,
  output logic                  protocol_err
);

  typedef enum logic [2:0] {
    LOAD,
    ARM,
    RUN,
    NEXT,
    FINISHED
  } state_t;

  localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0] NIN    = IDX_W'(N_IN);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(N_IN + N_OUT - 1);
  localparam logic [IDX_W-1:0] SLAST  = IDX_W'(NUM_SAMPLES - 1);
  localparam logic [IDX_W-1:0] EP_TR  = IDX_W'(TRAIN_EPOCHS);
  localparam logic [IDX_W-1:0] EP_END = IDX_W'(TRAIN_EPOCHS + 1);

  state_t           state;
  logic [IDX_W-1:0] word_cnt;
  logic [IDX_W-1:0] epoch_nxt;
  logic             xfer;

  assign xfer      = s_valid && s_ready && (state == LOAD);
  assign epoch_nxt = epoch_idx + ONE;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= LOAD;
      done         <= 1'b1;
      train        <= (TRAIN_EPOCHS > 0);
      s_ready      <= 1'b0;
      y0_we        <= 1'b0;
      y0_addr      <= '0;
      y0_data      <= '0;
      t_we         <= 1'b0;
      t_addr       <= '0;
      t_data       <= '0;
      word_cnt     <= '0;
      sample_idx   <= '0;
      epoch_idx    <= '0;
      finished     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      y0_we <= 1'b0;
      t_we  <= 1'b0;
      // valid is only meaningful while the controller is released
      if (valid && state != RUN)
        protocol_err <= 1'b1;
      unique case (state)
        LOAD: begin
          s_ready <= 1'b1;
          if (xfer) begin
            word_cnt <= word_cnt + ONE;
            if (word_cnt < NIN) begin
              y0_we   <= 1'b1;
              y0_addr <= word_cnt;
              y0_data <= s_data;
            end else begin
              t_we   <= 1'b1;
              t_addr <= word_cnt - NIN;
              t_data <= s_data;
            end
            if (word_cnt == LAST) begin
              s_ready  <= 1'b0;
              word_cnt <= '0;
              state    <= ARM;
            end
          end
        end
        ARM: begin
          done  <= 1'b0;
          state <= RUN;
        end
        RUN: begin
          // raise done on the consuming edge so INIT sees it at once
          if (valid) begin
            done  <= 1'b1;
            state <= NEXT;
          end
        end
        NEXT: begin
          if (sample_idx < SLAST) begin
            sample_idx <= sample_idx + ONE;
            s_ready    <= 1'b1;
            state      <= LOAD;
          end else begin
            sample_idx <= '0;
            epoch_idx  <= epoch_nxt;
            if (epoch_nxt == EP_TR)
              train <= 1'b0;
            if (epoch_nxt == EP_END) begin
              finished <= 1'b1;
              state    <= FINISHED;
            end else begin
              s_ready <= 1'b1;
              state   <= LOAD;
            end
          end
        end
        FINISHED: begin
          done    <= 1'b1;
          s_ready <= 1'b0;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_loader.sv
// tb_sample_loader: directed checks of loading, stalls, epoch sequencing,
// protocol errors and mid-load reset.
module tb_sample_loader;

  localparam int DW = 32;
  localparam int IW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          valid;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          y0_we;
  logic [IW-1:0] y0_addr;
  logic [DW-1:0] y0_data;
  logic          t_we;
  logic [IW-1:0] t_addr;
  logic [DW-1:0] t_data;
  logic          done;
  logic          train;
  logic [IW-1:0] sample_idx;
  logic [IW-1:0] epoch_idx;
  logic          finished;
  logic          protocol_err;

  int n_cmp = 0;
  int n_err = 0;

  sample_loader #(
    .DATA_WIDTH(DW),
    .N_IN(2),
    .N_OUT(1),
    .NUM_SAMPLES(2),
    .TRAIN_EPOCHS(1),
    .IDX_W(IW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .valid(valid),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .y0_we(y0_we),
    .y0_addr(y0_addr),
    .y0_data(y0_data),
    .t_we(t_we),
    .t_addr(t_addr),
    .t_data(t_data),
    .done(done),
    .train(train),
    .sample_idx(sample_idx),
    .epoch_idx(epoch_idx),
    .finished(finished),
    .protocol_err(protocol_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Three words: y0[0], y0[1], t[0]; then the ARM edge drops done.
  task automatic load3(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [DW-1:0] d2);
    s_valid = 1'b1;
    s_data  = d0;
    tick();
    chk("w0_y0we", y0_we, 1);
    chk("w0_addr", y0_addr, 0);
    chk("w0_data", y0_data, d0);
    chk("w0_twe", t_we, 0);
    s_data = d1;
    tick();
    chk("w1_y0we", y0_we, 1);
    chk("w1_addr", y0_addr, 1);
    chk("w1_data", y0_data, d1);
    s_data = d2;
    tick();
    chk("w2_twe", t_we, 1);
    chk("w2_addr", t_addr, 0);
    chk("w2_data", t_data, d2);
    chk("w2_y0we", y0_we, 0);
    chk("w2_srdy", s_ready, 0);
    chk("w2_done", done, 1);
    s_valid = 1'b0;
    tick();
    chk("arm_done", done, 0);
    chk("arm_twe", t_we, 0);
  endtask

  // Controller run: valid 10 cycles after done falls, then NEXT edge.
  task automatic run_valid(input logic exp_train);
    repeat (10) tick();
    chk("run_done", done, 0);
    chk("run_train", train, exp_train);
    chk("run_srdy", s_ready, 0);
    valid = 1'b1;
    tick();
    chk("valid_done", done, 1);
    valid = 1'b0;
    tick();
    chk("next_done", done, 1);
  endtask

  initial begin
    logic [5:0]  pat;
    logic [DW-1:0] wd [3];
    int wi;
    RST     = 1'b1;
    valid   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    tick();
    tick();
    chk("rst_done", done, 1);
    chk("rst_train", train, 1);
    chk("rst_srdy", s_ready, 0);
    chk("rst_y0we", y0_we, 0);
    chk("rst_twe", t_we, 0);
    chk("rst_y0addr", y0_addr, 0);
    chk("rst_taddr", t_addr, 0);
    chk("rst_sidx", sample_idx, 0);
    chk("rst_eidx", epoch_idx, 0);
    chk("rst_fin", finished, 0);
    chk("rst_perr", protocol_err, 0);

    // sample 0, epoch 0
    RST = 1'b0;
    tick();
    chk("load_srdy", s_ready, 1);
    load3(32'h10, 32'h20, 32'h30);
    run_valid(1'b1);
    chk("s1_sidx", sample_idx, 1);
    chk("s1_eidx", epoch_idx, 0);
    chk("s1_srdy", s_ready, 1);
    chk("s1_train", train, 1);

    // sample 1 with stalls 1,0,0,1,0,1
    pat   = 6'b101001;
    wd[0] = 32'h40;
    wd[1] = 32'h50;
    wd[2] = 32'h60;
    wi    = 0;
    for (int k = 0; k < 6; k++) begin
      s_valid = pat[k];
      s_data  = pat[k] ? wd[wi] : 32'hdead;
      tick();
      if (pat[k]) begin
        chk("st_y0we", y0_we, (wi < 2) ? 1 : 0);
        chk("st_twe", t_we, (wi == 2) ? 1 : 0);
        if (wi < 2) begin
          chk("st_y0addr", y0_addr, wi);
          chk("st_y0data", y0_data, wd[wi]);
        end else begin
          chk("st_taddr", t_addr, 0);
          chk("st_tdata", t_data, wd[2]);
        end
        wi++;
      end else begin
        chk("stall_y0we", y0_we, 0);
        chk("stall_twe", t_we, 0);
      end
    end
    s_valid = 1'b0;
    tick();
    chk("st_arm_done", done, 0);
    run_valid(1'b1);
    chk("e1_sidx", sample_idx, 0);
    chk("e1_eidx", epoch_idx, 1);
    chk("e1_train", train, 0);
    chk("e1_fin", finished, 0);

    // sample 2: spurious valid with the first word
    valid   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h71;
    tick();
    valid = 1'b0;
    chk("sp_perr", protocol_err, 1);
    chk("sp_y0we", y0_we, 1);
    chk("sp_addr", y0_addr, 0);
    chk("sp_done", done, 1);
    s_data = 32'h72;
    tick();
    chk("sp_w1addr", y0_addr, 1);
    chk("sp_w1data", y0_data, 32'h72);
    s_data = 32'h73;
    tick();
    chk("sp_w2twe", t_we, 1);
    chk("sp_w2data", t_data, 32'h73);
    s_valid = 1'b0;
    tick();
    chk("sp_arm_done", done, 0);
    chk("sp_sticky", protocol_err, 1);
    run_valid(1'b0);
    chk("s3_sidx", sample_idx, 1);
    chk("s3_eidx", epoch_idx, 1);

    // sample 3 (last) -> finished
    load3(32'h81, 32'h82, 32'h83);
    run_valid(1'b0);
    chk("fin_fin", finished, 1);
    chk("fin_eidx", epoch_idx, 2);
    chk("fin_sidx", sample_idx, 0);
    chk("fin_srdy", s_ready, 0);
    s_valid = 1'b1;
    s_data  = 32'h99;
    valid   = 1'b1;
    tick();
    valid = 1'b0;
    repeat (4) tick();
    chk("fin_hold_done", done, 1);
    chk("fin_hold_fin", finished, 1);
    chk("fin_no_y0we", y0_we, 0);
    chk("fin_srdy2", s_ready, 0);
    s_valid = 1'b0;

    // reset, then reset again after one of three words
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    chk("rs_fin", finished, 0);
    chk("rs_train", train, 1);
    s_valid = 1'b1;
    s_data  = 32'ha1;
    tick();
    chk("rs_w0", y0_we, 1);
    s_data = 32'ha2;
    RST    = 1'b1;
    tick();
    chk("rs_y0we", y0_we, 0);
    chk("rs_twe", t_we, 0);
    chk("rs_sidx", sample_idx, 0);
    chk("rs_done", done, 1);
    chk("rs_perr", protocol_err, 0);
    RST     = 1'b0;
    s_valid = 1'b0;
    tick();
    chk("rs_idle_we", y0_we | t_we, 0);
    chk("rs_srdy", s_ready, 1);
    load3(32'hb1, 32'hb2, 32'hb3);
    chk("rs_eidx", epoch_idx, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
